// File: rtl/multiplexor_7seg_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment driver:
// active-low hex segment patterns, all-off values and FSM encodings.
package multiplexor_7seg_pkg;

  // Active-low {dp,g,f,e,d,c,b,a}; dp bit is off (1) in every pattern.
  // Entry [n] is the pattern for hex digit n.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
    8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

  localparam logic [7:0] SEG_APAGADO = 8'hFF;
  localparam logic [3:0] AN_APAGADO  = 4'b1111;

  // FSM: SHOW drives one anode (or none right after reset), BLANK is dead time.
  localparam logic ST_SHOW  = 1'b0;
  localparam logic ST_BLANK = 1'b1;

endpackage

// File: rtl/multiplexor_7seg_decodificador.sv
// Combinational hex nibble to active-low a..g segment pattern.
module decodificador_7seg
  import multiplexor_7seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  logic [7:0] pat;

  // Table lookup; dp is handled by the caller.
  always_comb begin
    pat   = SEG_HEX[hex_i];
    seg_o = pat[6:0];
  end

endmodule

// File: rtl/multiplexor_7seg.sv
// Time-multiplexed 4-digit common-anode display driver. One digit advance
// per rising edge of the ms scan strobe, followed by BLANK_CYCLES clocks of
// all-anodes-off before the new digit is driven.
module multiplexor_7seg
  import multiplexor_7seg_pkg::*;
#(
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clock_FPGA,
  input  logic        reset_n,
  input  logic        reloj_N_ms,
  input  logic [15:0] digitos,
  input  logic [3:0]  puntos,
  input  logic        supr_ceros,
  output logic [7:0]  segmentos,
  output logic [3:0]  anodos
);

  localparam logic [7:0] CNT_FIN = 8'(BLANK_CYCLES - 1);

  logic        reloj_prev_q, reloj_prev_d;
  logic        estado_q, estado_d;
  logic [1:0]  indice_q, indice_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] snap_dig_q, snap_dig_d;
  logic [3:0]  snap_pt_q, snap_pt_d;
  logic        snap_sup_q, snap_sup_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  logic        flanco;
  logic [3:0]  nib;
  logic [6:0]  seg_dec;
  logic        digito_vacio;
  logic [1:0]  indice_sig;

  assign flanco     = reloj_N_ms & ~reloj_prev_q;
  assign indice_sig = indice_q + 2'd1;

  // Nibble and leading-zero test for the digit about to be shown, taken
  // from the frame snapshot so a frame never mixes two input values.
  always_comb begin
    nib          = snap_dig_q[{indice_q, 2'b00} +: 4];
    digito_vacio = 1'b0;
    case (indice_q)
      2'd1:    digito_vacio = snap_sup_q && (snap_dig_q[15:4]  == 12'h000);
      2'd2:    digito_vacio = snap_sup_q && (snap_dig_q[15:8]  == 8'h00);
      2'd3:    digito_vacio = snap_sup_q && (snap_dig_q[15:12] == 4'h0);
      default: digito_vacio = 1'b0;
    endcase
  end

  decodificador_7seg u_dec (
    .hex_i (nib),
    .seg_o (seg_dec)
  );

  // Next-state logic for the scan FSM, counter, index, snapshot and outputs.
  always_comb begin
    reloj_prev_d = reloj_N_ms;
    estado_d     = estado_q;
    indice_d     = indice_q;
    cnt_d        = cnt_q;
    snap_dig_d   = snap_dig_q;
    snap_pt_d    = snap_pt_q;
    snap_sup_d   = snap_sup_q;
    seg_d        = seg_q;
    an_d         = an_q;
    case (estado_q)
      ST_SHOW: begin
        if (flanco) begin
          estado_d = ST_BLANK;
          an_d     = AN_APAGADO;
          indice_d = indice_sig;
          cnt_d    = 8'd0;
          if (indice_sig == 2'd0) begin
            snap_dig_d = digitos;
            snap_pt_d  = puntos;
            snap_sup_d = supr_ceros;
          end
        end
      end
      default: begin
        // Strobe edges are deliberately ignored while blanking.
        if (cnt_q == CNT_FIN) begin
          estado_d = ST_SHOW;
          seg_d    = {~snap_pt_q[indice_q], digito_vacio ? 7'h7F : seg_dec};
          an_d     = ~(4'b0001 << indice_q);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // State registers; reloj_prev resets high so a strobe already high at
  // reset release is not taken as an edge.
  always_ff @(posedge clock_FPGA or negedge reset_n) begin
    if (!reset_n) begin
      reloj_prev_q <= 1'b1;
      estado_q     <= ST_SHOW;
      indice_q     <= 2'd3;
      cnt_q        <= 8'd0;
      snap_dig_q   <= 16'h0000;
      snap_pt_q    <= 4'h0;
      snap_sup_q   <= 1'b0;
      seg_q        <= SEG_APAGADO;
      an_q         <= AN_APAGADO;
    end else begin
      reloj_prev_q <= reloj_prev_d;
      estado_q     <= estado_d;
      indice_q     <= indice_d;
      cnt_q        <= cnt_d;
      snap_dig_q   <= snap_dig_d;
      snap_pt_q    <= snap_pt_d;
      snap_sup_q   <= snap_sup_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign segmentos = seg_q;
  assign anodos    = an_q;

endmodule

// File: tb/tb_multiplexor_7seg.sv
// Self-checking bench for multiplexor_7seg: directed scenarios plus a
// randomized run against a frame-level reference model.
module tb_multiplexor_7seg;

  localparam int B = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reloj;
  logic [15:0] dig;
  logic [3:0]  pt;
  logic        sup;
  logic [7:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the display should be doing per frame.
  int          m_idx;
  logic [15:0] m_dig;
  logic [3:0]  m_pt;
  logic        m_sup;

  logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  multiplexor_7seg #(.BLANK_CYCLES(B)) dut (
    .clock_FPGA (clk),
    .reset_n    (rst_n),
    .reloj_N_ms (reloj),
    .digitos    (dig),
    .puntos     (pt),
    .supr_ceros (sup),
    .segmentos  (seg),
    .anodos     (an)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_seg(input int i);
    int   v;
    logic vacio;
    logic [6:0] s7;
    v     = int'(m_dig) >> (4 * i);
    vacio = m_sup && (i >= 1) && (v == 0);
    s7    = vacio ? 7'h7F : HEX[v % 16][6:0];
    return {~m_pt[i], s7};
  endfunction

  function automatic logic [3:0] m_an(input int i);
    return 4'hF ^ 4'(1 << i);
  endfunction

  task automatic m_reset();
    m_idx = 3; m_dig = '0; m_pt = '0; m_sup = 1'b0;
  endtask

  // One strobe edge: expect B clocks dark, then the next digit. If use_lit,
  // the literal pair is the expectation; otherwise the model supplies it.
  task automatic scan(input string tag, input bit use_lit, input logic [3:0] la,
                      input logic [7:0] ls, input bit inject);
    logic [3:0] ea;
    logic [7:0] es;
    @(negedge clk);
    reloj = 1'b1;
    m_idx = (m_idx + 1) % 4;
    if (m_idx == 0) begin m_dig = dig; m_pt = pt; m_sup = sup; end
    ea = use_lit ? la : m_an(m_idx);
    es = use_lit ? ls : m_seg(m_idx);
    for (int k = 0; k < B; k++) begin
      @(negedge clk);
      reloj = inject && (k == 1);
      chk({tag, "_dark"}, {4'h0, an}, 8'h0F);
    end
    @(negedge clk);
    chk({tag, "_an"}, {4'h0, an}, {4'h0, ea});
    chk({tag, "_seg"}, seg, es);
    repeat (2) @(negedge clk);
    chk({tag, "_hold"}, {4'h0, an}, {4'h0, ea});
  endtask

  initial begin
    rst_n = 1'b0; reloj = 1'b0; dig = '0; pt = '0; sup = 1'b0;
    m_reset();

    // Reset held with random inputs.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reloj = 1'($urandom); dig = 16'($urandom); pt = 4'($urandom); sup = 1'($urandom);
      chk("rst_an", {4'h0, an}, 8'h0F);
      chk("rst_seg", seg, 8'hFF);
    end
    // Release with the strobe already high: no edge, stays dark.
    @(negedge clk); reloj = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_an", {4'h0, an}, 8'h0F);
      chk("idle_seg", seg, 8'hFF);
    end
    @(negedge clk); reloj = 1'b0;

    // Basic scan order and decode.
    dig = 16'h1234; pt = 4'h0; sup = 1'b0;
    scan("d1234_0", 1, 4'hE, 8'h99, 0);
    scan("d1234_1", 1, 4'hD, 8'hB0, 0);
    scan("d1234_2", 1, 4'hB, 8'hA4, 0);
    scan("d1234_3", 1, 4'h7, 8'hF9, 0);

    // Leading-zero suppression with a decimal point on a blanked digit.
    dig = 16'h00A5; pt = 4'b0100; sup = 1'b1;
    scan("lz_0", 1, 4'hE, 8'h92, 0);
    scan("lz_1", 1, 4'hD, 8'h88, 0);
    scan("lz_2", 1, 4'hB, 8'h7F, 0);
    scan("lz_3", 1, 4'h7, 8'hFF, 0);

    // All zeros: only digit 0 lit.
    dig = 16'h0000; pt = 4'h0; sup = 1'b1;
    scan("z_0", 1, 4'hE, 8'hC0, 0);
    scan("z_1", 1, 4'hD, 8'hFF, 0);
    scan("z_2", 1, 4'hB, 8'hFF, 0);
    scan("z_3", 1, 4'h7, 8'hFF, 0);

    // Mid-frame input change only takes effect from the next frame.
    dig = 16'h1111; sup = 1'b0;
    scan("snap_0", 1, 4'hE, 8'hF9, 0);
    scan("snap_1", 1, 4'hD, 8'hF9, 0);
    dig = 16'h2222;
    scan("snap_2", 1, 4'hB, 8'hF9, 0);
    scan("snap_3", 1, 4'h7, 8'hF9, 0);
    scan("snap_4", 1, 4'hE, 8'hA4, 0);
    scan("snap_5", 1, 4'hD, 8'hA4, 0);

    // Extra edge during dead time advances the index by one only.
    scan("inj", 1, 4'hB, 8'hA4, 1);
    scan("inj_next", 1, 4'h7, 8'hA4, 0);

    // Randomized inputs against the model.
    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        dig = 16'($urandom);
        if ($urandom_range(0, 1) == 1) dig = dig & (16'hFFFF >> (4 * $urandom_range(1, 4)));
        pt  = 4'($urandom);
        sup = 1'($urandom);
      end
      scan("rnd", 0, 4'h0, 8'h00, bit'($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of dead time.
    @(negedge clk); reloj = 1'b1;
    @(negedge clk); reloj = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", {4'h0, an}, 8'h0F);
    chk("arst_seg", seg, 8'hFF);
    @(negedge clk); rst_n = 1'b1;
    m_reset();
    repeat (B + 2) @(negedge clk);
    chk("post_an", {4'h0, an}, 8'h0F);
    chk("post_seg", seg, 8'hFF);
    dig = 16'h0C07; pt = 4'b0001; sup = 1'b1;
    scan("post_0", 0, 4'h0, 8'h00, 0);
    scan("post_1", 0, 4'h0, 8'h00, 0);
    scan("post_2", 0, 4'h0, 8'h00, 0);
    scan("post_3", 0, 4'h0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplexor_7seg.md
# multiplexor_7seg

Time-multiplexed driver for the board's 4-digit common-anode 7-segment display. It consumes the slow square wave produced by the millisecond clock divider (`reloj_N_ms`) and advances one digit per rising edge of that wave. Each digit is displayed with a programmable all-off dead time to suppress ghosting. It decodes hex nibbles to segment patterns, drives per-digit decimal points and optionally suppresses leading zeros. It sits between the divider and the FPGA pins.

## Interface
- `BLANK_CYCLES`, default 64: `clock_FPGA` cycles with all anodes off after each digit change; legal range 1..255.
- `clock_FPGA`  in  1  system clock (50 MHz); all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `reloj_N_ms`  in  1  scan strobe from the ms divider. It is a square wave synchronous to `clock_FPGA`; only its rising edges are used.
- `digitos`  in  16  four hex nibbles; `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3.
- `puntos`  in  4  decimal point per digit, active-high; bit i goes with digit i.
- `supr_ceros`  in  1  leading-zero suppression enable.
- `segmentos`  out  8  `{dp,g,f,e,d,c,b,a}`, active-low, registered.
- `anodos`  out  4  digit enables, active-low one-hot or all-high, registered; bit i is digit i.

## Operation
- Edge detect: register `reloj_prev` holds the previous value of `reloj_N_ms`. Its reset value is 1, so an input that is already high at reset release does not produce an edge. An edge is `reloj_N_ms & ~reloj_prev`.
- State machine, two states:
  - SHOW: one anode asserted, or all off right after reset.
  - BLANK: all anodes off, dead-time counter running.
- Reset values: state = SHOW, `indice` = 3, `anodos` = 4'b1111, `segmentos` = 8'hFF, snapshot registers = 0, dead-time counter = 0.
- Transition SHOW → BLANK on an edge, in a single clock:
  - `anodos` ← 4'b1111.
  - `indice` ← `indice` + 1, mod 4, so the order is 0,1,2,3,0,…
  - Dead-time counter ← 0.
  - If the new `indice` is 0 (frame start), snapshot `digitos`, `puntos` and `supr_ceros`.
- In BLANK, the counter increments every clock.
- Transition BLANK → SHOW on the clock where counter = `BLANK_CYCLES`−1:
  - `segmentos` ← decode(snapshot nibble[`indice`]), with dp bit cleared if snapshot `puntos[indice]` = 1.
  - `anodos` ← ~(1 << `indice`).
- Edges arriving while in BLANK are ignored: no index skip, no counter restart.
- Leading-zero suppression applies when the snapshot of `supr_ceros` = 1. Digit i (i ≥ 1) is blank when every snapshot nibble from 3 down to i is 0.
  - A blank digit shows segments a–g off (7 bits high), but its dp is still honoured and its anode is still asserted.
  - Digit 0 is never blanked.
- All inputs other than `reloj_N_ms` are used only through the frame snapshot, so a frame never mixes two values of `digitos`.
- An asynchronous reset at any point returns every register to its reset value immediately.

## Timing
- If the edge is sampled at clock edge E, anodes go off at E. The new digit appears at E+`BLANK_CYCLES`, so anodes are off for exactly `BLANK_CYCLES` clocks.
- With `CANT_MS`=1 on the divider: one rising edge every 2 ms, so each digit shows for 2 ms, a frame takes 8 ms and the refresh rate is 125 Hz.
- After reset, the display stays dark until the first rising edge plus `BLANK_CYCLES`; digit 0 is then shown first.
- The latency from a `digitos` change to its display is at most one frame plus `BLANK_CYCLES`.

## Structure
- `definiciones.vh` holds:
  - hex segment constants, active-low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E;
  - `SEG_APAGADO` = 8'hFF and `AN_APAGADO` = 4'b1111;
  - the state encodings.
- One sub-module, `decodificador_7seg`: combinational 4-bit hex to 7-bit active-low segments.
- The top level holds the edge detector, state machine, counter, index, snapshot and output registers.

## Test plan
- Reset held low with random inputs → `anodos` = F and `segmentos` = FF throughout. After release, with no edge, outputs stay unchanged.
- `digitos` = 16'h1234, `puntos` = 0, `BLANK_CYCLES` = 4, four edges → successive outputs `(anodos, segmentos)` = (E,99), (D,B0), (B,A4), (7,F9). Each is preceded by exactly 4 clocks of `anodos` = F.
- `digitos` = 16'h00A5, `supr_ceros` = 1, `puntos` = 4'b0100 → digit 0 = 92, digit 1 = 88, digit 2 = 7F (blank with dp), digit 3 = FF.
- `digitos` = 0 with `supr_ceros` = 1 → digits 3..1 show FF and digit 0 shows C0.
- `digitos` changed from 16'h1111 to 16'h2222 while digit 1 is displayed → digits 2 and 3 of the current frame still show F9; C0 … A4 (the value 2) appears only from the next digit 0 onward.
- A second `reloj_N_ms` edge injected during BLANK → ignored, and the index advances by 1 only. `reset_n` pulsed low mid-BLANK → outputs return to F/FF asynchronously.
